// File: rtl/wb_wait_ram.sv
// Wishbone classic slave RAM with a fixed 1..4 cycle request-to-ack latency.
// Define WB_RAM_ERR_EN to add bus__err and reject addresses above the decoded range.
module wb_wait_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus__adr,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic        bus__we,
  input  logic [3:0]  bus__sel,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
`ifdef WB_RAM_ERR_EN
  output logic        bus__err,
`endif
  output logic        bus__ack
);

  if (WAIT_STATES < 1 || WAIT_STATES > 4) begin : g_bad_wait_states
    $error("wb_wait_ram: WAIT_STATES must be in 1..4");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [1:0] CNT_INIT = 2'(WAIT_STATES - 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_w_q;
  logic [31:0]           dat_r_q;
  logic                  ack_q;
  logic                  err_q;

  logic                  req;
  logic                  latch_en;
  logic                  access;
  logic [ADDR_WIDTH-1:0] acc_adr;
  logic                  acc_we;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_dat;
  logic                  acc_oor;
  logic                  unused_adr_hi;

  assign req           = bus__cyc & bus__stb;
  assign unused_adr_hi = ^(bus__adr >> ADDR_WIDTH);

  // With one wait state the access happens on the accepting edge, so use live bus values.
  always_comb begin
    if (state_q == IDLE) begin
      acc_adr = bus__adr[ADDR_WIDTH-1:0];
      acc_we  = bus__we;
      acc_sel = bus__sel;
      acc_dat = bus__dat_w;
    end else begin
      acc_adr = adr_q;
      acc_we  = we_q;
      acc_sel = sel_q;
      acc_dat = dat_w_q;
    end
  end

`ifdef WB_RAM_ERR_EN
  logic oor_q;
  assign acc_oor = (state_q == IDLE) ? ((bus__adr >> ADDR_WIDTH) != 30'd0) : oor_q;
`else
  assign acc_oor = 1'b0;
`endif

  // The counter holds the remaining WAIT cycles; leaving WAIT at 1 lands ACK at T+WAIT_STATES.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    access   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          if (WAIT_STATES == 1) begin
            state_d = ACK;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus__cyc) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q <= 2'd1) begin
          state_d = ACK;
          cnt_d   = 2'd0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      dat_w_q <= 32'h0;
      dat_r_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= access & ~acc_oor;
      err_q   <= access & acc_oor;
      if (latch_en) begin
        adr_q   <= bus__adr[ADDR_WIDTH-1:0];
        we_q    <= bus__we;
        sel_q   <= bus__sel;
        dat_w_q <= bus__dat_w;
      end
      if (access && !acc_we && !acc_oor) begin
        dat_r_q <= mem[acc_adr];
      end
    end
  end

`ifdef WB_RAM_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (latch_en) begin
      oor_q <= (bus__adr >> ADDR_WIDTH) != 30'd0;
    end
  end
  assign bus__err = err_q;
`endif

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          mem[acc_adr][8*b +: 8] <= acc_dat[8*b +: 8];
        end
      end
    end
  end

  assign bus__ack   = ack_q;
  assign bus__dat_r = dat_r_q;

endmodule
